// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the IF/ID register, PC and ID/EX register.
//
// Detects load-use hazards (load in EX feeding a source of the ID instruction)
// and control hazards (taken branch/jump resolved in EX). Multi-cycle windows
// are held by a small FSM with a 2-bit down-counter; control hazards win.
// Saturating counters record cycles spent stalling and flushing.
//
// State table:
//   state  | meaning
//   S_IDLE | no window open; outputs follow the current-cycle hazards
//   S_LU   | inside a load-use stall window, rem cycles left incl. this one
//   S_CA   | inside a control-hazard flush window, rem cycles left incl. this one
//
// Ports:
//   Clk, Rst_n            clock, async active-low reset
//   ID_rs, ID_rt          source fields of the ID instruction
//   ID_uses_rt            ID instruction reads rt
//   EX_MemRead, EX_rt     load in EX and its destination
//   Branch_taken          EX branch/jump resolved taken
//   Bubble_from_ca        flush IF/ID
//   Bubble_from_loaduse   hold IF/ID
//   PC_hold               freeze PC
//   IDEX_flush            ID/EX loads a NOP
//   Stall_count           saturating count of load-use stall cycles
//   Flush_count           saturating count of control-hazard flush cycles
module hazard_ctrl #(
    parameter int LU_CYCLES = 1,
    parameter int CA_CYCLES = 1,
    parameter int CNT_W     = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             Branch_taken,
    output logic             Bubble_from_ca,
    output logic             Bubble_from_loaduse,
    output logic             PC_hold,
    output logic             IDEX_flush,
    output logic [CNT_W-1:0] Stall_count,
    output logic [CNT_W-1:0] Flush_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LU   = 2'd1,
        S_CA   = 2'd2
    } state_t;

    localparam logic [1:0]       LU_RELOAD = 2'(LU_CYCLES - 1);
    localparam logic [1:0]       CA_RELOAD = 2'(CA_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_n;
    logic [1:0] rem, rem_n;
    logic       lu_hit;
    logic       ca_c, lu_c;

    assign lu_hit = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            rem   <= 2'd0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        ca_c    = 1'b0;
        lu_c    = 1'b0;
        // A taken branch behaves identically from every state: it preempts a
        // stall window and restarts a flush window.
        if (Branch_taken) begin
            ca_c = 1'b1;
            if (CA_CYCLES > 1) begin
                state_n = S_CA;
                rem_n   = CA_RELOAD;
            end else begin
                state_n = S_IDLE;
                rem_n   = 2'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (lu_hit) begin
                        lu_c = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_n = S_LU;
                            rem_n   = LU_RELOAD;
                        end
                    end
                end
                S_LU: begin
                    lu_c = 1'b1;
                    if (rem == 2'd1) begin
                        state_n = S_IDLE;
                        rem_n   = 2'd0;
                    end else begin
                        rem_n = rem - 2'd1;
                    end
                end
                S_CA: begin
                    ca_c = 1'b1;
                    if (rem == 2'd1) begin
                        state_n = S_IDLE;
                        rem_n   = 2'd0;
                    end else begin
                        rem_n = rem - 2'd1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    rem_n   = 2'd0;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as reset is held, not just after the
    // state register clears.
    assign Bubble_from_ca      = ca_c & Rst_n;
    assign Bubble_from_loaduse = lu_c & Rst_n;
    assign PC_hold             = lu_c & Rst_n;
    assign IDEX_flush          = (ca_c | lu_c) & Rst_n;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stall_count <= '0;
            Flush_count <= '0;
        end else begin
            if (Bubble_from_loaduse && (Stall_count != CNT_MAX))
                Stall_count <= Stall_count + CNT_W'(1);
            if (Bubble_from_ca && (Flush_count != CNT_MAX))
                Flush_count <= Flush_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard control unit that drives the stall and flush controls for the IF/ID pipeline register, the PC, and the ID/EX register in the five-stage pipeline. It detects load-use data hazards from the ID and EX stage fields. It detects control hazards from the EX-stage taken-branch signal. It holds multi-cycle stall and flush windows in a small state machine and keeps saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- LU_CYCLES, 1, load-use stall length in cycles; legal range 1–3.
- CA_CYCLES, 1, control-hazard flush length in cycles; legal range 1–3.
- CNT_W, 32, width of each performance counter.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_uses_rt  in  1  ID instruction reads rt as a source.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_rt  in  5  destination register of the load in EX.
- Branch_taken  in  1  EX-stage branch or jump resolved taken.
- Bubble_from_ca  out  1  flush IF/ID; IF/ID loads zeros.
- Bubble_from_loaduse  out  1  hold IF/ID.
- PC_hold  out  1  PC does not update.
- IDEX_flush  out  1  ID/EX loads a NOP.
- Stall_count  out  CNT_W  cycles in which Bubble_from_loaduse was asserted.
- Flush_count  out  CNT_W  cycles in which Bubble_from_ca was asserted.

## Operation
- Load-use hit is defined as: lu_hit = EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_uses_rt && EX_rt==ID_rt)).
- The FSM has three states: IDLE, LU, CA. A down-counter rem (2 bits) tracks the remaining window.
- Behaviour in IDLE:
  - If Branch_taken: assert Bubble_from_ca and IDEX_flush. If CA_CYCLES>1, go to CA with rem=CA_CYCLES-1.
  - Else if lu_hit: assert Bubble_from_loaduse, PC_hold and IDEX_flush. If LU_CYCLES>1, go to LU with rem=LU_CYCLES-1.
  - Otherwise all control outputs are 0.
- Behaviour in LU:
  - Assert Bubble_from_loaduse, PC_hold and IDEX_flush. EX_MemRead and lu_hit are ignored.
  - rem decrements each cycle. When rem==1, return to IDLE.
  - Branch_taken in LU preempts the stall: behave as in IDLE with Branch_taken (flush outputs this cycle, load CA window).
- Behaviour in CA:
  - Assert Bubble_from_ca and IDEX_flush. PC_hold=0, so the PC follows the branch target.
  - rem decrements. When rem==1, return to IDLE.
  - A new Branch_taken reloads rem=CA_CYCLES-1 (when CA_CYCLES>1).
  - lu_hit is ignored.
- Priority is control hazard over load-use. Bubble_from_ca and Bubble_from_loaduse are never 1 in the same cycle.
- Counters:
  - Stall_count increments on every rising edge where Bubble_from_loaduse=1.
  - Flush_count increments on every rising edge where Bubble_from_ca=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (Rst_n=0), effective immediately:
  - State returns to IDLE, rem=0, and both counters are 0.
  - All control outputs are forced to 0 while Rst_n=0.
  - A reset during LU or CA abandons the window.

## Timing
- Control outputs are combinational from the inputs and the current state. They are valid in the same cycle the hazard is visible and are sampled by IF/ID, PC and ID/EX at the next rising edge.
- With LU_CYCLES=1 there is exactly one stall cycle and no state change. With LU_CYCLES=N, outputs stay high for N consecutive cycles.
- With CA_CYCLES=N, Bubble_from_ca stays high for N consecutive cycles from the cycle Branch_taken is seen.
- Counter values reflect cycles up to and including the previous edge, with one cycle of latency.
- After Rst_n deasserts, the first rising edge evaluates from IDLE.

## Test plan
- Reset: Rst_n=0 mid-LU with LU_CYCLES=2 -> all outputs 0 and counters 0 immediately; after release, with no hazard, outputs stay 0.
- Load-use, LU_CYCLES=1: EX_MemRead=1, EX_rt=5, ID_rs=5 for one cycle -> Bubble_from_loaduse, PC_hold and IDEX_flush high for exactly 1 cycle; Stall_count=1.
- Load-use, LU_CYCLES=2 with ID_uses_rt=0, EX_rt=ID_rt=7, ID_rs=3 -> no stall. Repeat with ID_uses_rt=1 -> 2-cycle stall; Stall_count=2. Repeat with EX_rt=0 -> no stall.
- Branch, CA_CYCLES=2: Branch_taken pulse -> Bubble_from_ca and IDEX_flush high for 2 cycles, PC_hold=0; Flush_count=2.
- Simultaneous events: Branch_taken=1 with lu_hit=1 in IDLE -> only the ca outputs assert. Branch_taken during an LU window -> immediate switch to the CA window; Bubble_from_loaduse drops that cycle.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> Stall_count holds at 15.
